// File: rtl/mfd_vector_checker_if.sv
// Bus between the MFD vector checker and its environment (stimulus source / table loader).
// err_map is present only when MFD_CHK_ERRMAP_EN is defined.
interface mfd_vector_checker_if #(
    parameter int WIDTH = 4,
    parameter int OUT_W = 2,
    parameter int ERR_W = 5
);
    localparam int N = 2 ** WIDTH;

    logic             start;
    logic [WIDTH-1:0] abcd_out;
    logic [OUT_W-1:0] f_in;
    logic             exp_we;
    logic [WIDTH-1:0] exp_addr;
    logic [OUT_W-1:0] exp_data;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] first_err_addr;
    logic             first_err_vld;
`ifdef MFD_CHK_ERRMAP_EN
    logic [N-1:0]     err_map;
`endif

    // The environment requests sweeps, loads the table and feeds the MFD response.
    modport master (
        output start, f_in, exp_we, exp_addr, exp_data,
        input  abcd_out, busy, done, pass, err_count, first_err_addr, first_err_vld
`ifdef MFD_CHK_ERRMAP_EN
        , input err_map
`endif
    );

    modport slave (
        input  start, f_in, exp_we, exp_addr, exp_data,
        output abcd_out, busy, done, pass, err_count, first_err_addr, first_err_vld
`ifdef MFD_CHK_ERRMAP_EN
        , output err_map
`endif
    );
endinterface

// File: rtl/mfd_vector_checker.sv
// Sweeps all ABCD codes into the MFD circuit and checks F1/F2 against a loadable table.
// Define MFD_CHK_ERRMAP_EN to add the per-vector err_map output.
module mfd_vector_checker #(
    parameter int WIDTH  = 4,
    parameter int OUT_W  = 2,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mfd_vector_checker_if.slave   bus
);
    localparam int N     = 2 ** WIDTH;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
    localparam logic [WIDTH-1:0] LAST     = WIDTH'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_abcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy, r_done, r_pass, r_any_err, r_first_vld;
    logic [ERR_W-1:0] r_err;
    logic [WIDTH-1:0] r_first_addr;
    logic [OUT_W-1:0] r_exp [N];
    logic             w_accept, w_sample, w_last, w_mismatch;

    // NOTE: the expected table has no reset; it is loaded before use and keeping
    // it out of reset lets it map onto plain RAM/flops without a clear path.
    always_ff @(posedge clk) begin
        if (bus.exp_we && !r_busy) r_exp[bus.exp_addr] <= bus.exp_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (bus.start) w_next = S_SETTLE;
            S_SETTLE:       if (r_cnt == '0) w_next = S_SAMPLE;
            S_SAMPLE:       w_next = w_last ? S_DONE : S_SETTLE;
            default:        w_next = S_IDLE;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_accept = 1'b0;
        w_sample = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: w_accept = bus.start;
            S_SAMPLE:       w_sample = 1'b1;
            default:        ;
        endcase
    end

    assign w_last     = (r_abcd == LAST);
    assign w_mismatch = (bus.f_in != r_exp[r_abcd]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abcd       <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_any_err    <= 1'b0;
            r_err        <= '0;
            r_first_addr <= '0;
            r_first_vld  <= 1'b0;
        end else if (w_accept) begin
            r_abcd       <= '0;
            r_cnt        <= CNT_INIT;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_any_err    <= 1'b0;
            r_err        <= '0;
            r_first_addr <= '0;
            r_first_vld  <= 1'b0;
        end else if (r_state == S_SETTLE) begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end else if (w_sample) begin
            if (w_mismatch) begin
                if (r_err != '1) r_err <= r_err + 1'b1;
                if (!r_any_err) begin
                    r_first_addr <= r_abcd;
                    r_first_vld  <= 1'b1;
                end
                r_any_err <= 1'b1;
            end
            if (w_last) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                // Sticky flag, so pass stays correct after err_count saturates.
                r_pass <= !(r_any_err || w_mismatch);
            end else begin
                r_abcd <= r_abcd + 1'b1;
                r_cnt  <= CNT_INIT;
            end
        end
    end

`ifdef MFD_CHK_ERRMAP_EN
    logic [N-1:0] r_err_map;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_err_map <= '0;
        else if (w_accept) r_err_map <= '0;
        else if (w_sample) r_err_map[r_abcd] <= w_mismatch;
    end

    assign bus.err_map = r_err_map;
`endif

    assign bus.abcd_out       = r_abcd;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.err_count      = r_err;
    assign bus.first_err_addr = r_first_addr;
    assign bus.first_err_vld  = r_first_vld;
endmodule

// File: tb/tb_mfd_vector_checker.sv
// Bench for mfd_vector_checker: default instance checked every cycle against a
// sweep-level model; SETTLE=3 and ERR_W=3 instances checked with literal expectations.
module tb_mfd_vector_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    mfd_vector_checker_if #(.WIDTH(4), .OUT_W(2), .ERR_W(5)) ifa ();
    mfd_vector_checker_if #(.WIDTH(4), .OUT_W(2), .ERR_W(5)) ifb ();
    mfd_vector_checker_if #(.WIDTH(4), .OUT_W(2), .ERR_W(3)) ifc ();

    mfd_vector_checker                            dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    mfd_vector_checker #(.SETTLE(3))              dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    mfd_vector_checker #(.SETTLE(1), .ERR_W(3))   dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    // Stand-in for the combinational MFD circuit.
    function automatic logic [1:0] golden(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return {(a & b) | (c & ~d), a ^ b ^ c ^ d};
    endfunction

    assign ifa.f_in = golden(ifa.abcd_out);
    assign ifb.f_in = golden(ifb.abcd_out);
    assign ifc.f_in = golden(ifc.abcd_out);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [16:0] vec_a();
        return {ifa.abcd_out, ifa.busy, ifa.done, ifa.pass, ifa.err_count,
                ifa.first_err_addr, ifa.first_err_vld};
    endfunction

    // Sweep-level model of instance A: edges since the accepted start plus the
    // mismatch pattern fixed at that start determine every output.
    bit         m_run = 1'b0;
    int         m_e = 0;
    bit         m_busy_now;
    logic [1:0] m_exp [16];
    bit  [15:0] m_mis;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0;
            m_e   = 0;
        end else begin
            m_busy_now = m_run && (m_e < 32);
            if (ifa.exp_we && !m_busy_now) m_exp[ifa.exp_addr] = ifa.exp_data;
            if (ifa.start && !m_busy_now) begin
                m_run = 1'b1;
                m_e   = 0;
                for (int k = 0; k < 16; k++) m_mis[k] = (m_exp[k] !== golden(4'(k)));
            end else if (m_run && m_e < 32) begin
                m_e++;
            end
        end
    end

    function automatic logic [16:0] model_out();
        int   smp, errs;
        logic [3:0] fa;
        logic fv, busy;
        if (!m_run) return '0;
        smp  = (m_e / 2 > 16) ? 16 : m_e / 2;
        busy = (m_e < 32);
        errs = 0;
        fa   = '0;
        fv   = 1'b0;
        for (int k = 0; k < smp; k++) begin
            if (m_mis[k]) begin
                if (!fv) fa = 4'(k);
                fv = 1'b1;
                errs++;
            end
        end
        return {4'((smp > 15) ? 15 : smp), busy, !busy, !busy && (errs == 0),
                5'((errs > 31) ? 31 : errs), fa, fv};
    endfunction

    always @(negedge clk) begin
        if (cmp_en) check("cycle_a", 32'(vec_a()), 32'(model_out()));
    end

    task automatic write_a(input logic [3:0] addr, input logic [1:0] data);
        @(negedge clk);
        ifa.exp_we   = 1'b1;
        ifa.exp_addr = addr;
        ifa.exp_data = data;
        @(negedge clk);
        ifa.exp_we = 1'b0;
    endtask

    // One sweep of instance A with optional mid-sweep pokes (cycle numbers after the start edge).
    task automatic sweep_a(input bit co_write, input int poke_start, input int poke_we,
                           input int poke_rst);
        int cyc;
        cyc = 0;
        @(negedge clk);
        ifa.start = 1'b1;
        if (co_write) begin
            ifa.exp_we   = 1'b1;
            ifa.exp_addr = 4'd3;
            ifa.exp_data = ~golden(4'd3);
        end
        @(posedge clk);
        #1;
        ifa.start  = 1'b0;
        ifa.exp_we = 1'b0;
        while (!ifa.done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            ifa.start  = 1'b0;
            ifa.exp_we = 1'b0;
            if (cyc == poke_start) ifa.start = 1'b1;
            if (cyc == poke_we) begin
                ifa.exp_we   = 1'b1;
                ifa.exp_addr = 4'd15;
                ifa.exp_data = ~golden(4'd15);
            end
            if (cyc == poke_rst) begin
                rst_n = 1'b0;
                #1;
                check("reset_abort", 32'(vec_a()), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        check("done_cycle_a", cyc, 32);
    endtask

    initial begin
        int cb, cc, cyc;
        {ifa.start, ifa.exp_we, ifa.exp_addr, ifa.exp_data} = '0;
        {ifb.start, ifb.exp_we, ifb.exp_addr, ifb.exp_data} = '0;
        {ifc.start, ifc.exp_we, ifc.exp_addr, ifc.exp_data} = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state_a", 32'(vec_a()), 32'd0);
        check("reset_state_b", 32'({ifb.abcd_out, ifb.busy, ifb.done, ifb.err_count}), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // A gets the golden table; B and C get every entry wrong.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            {ifa.exp_we, ifb.exp_we, ifc.exp_we} = 3'b111;
            ifa.exp_addr = 4'(i);
            ifb.exp_addr = 4'(i);
            ifc.exp_addr = 4'(i);
            ifa.exp_data = golden(4'(i));
            ifb.exp_data = ~golden(4'(i));
            ifc.exp_data = ~golden(4'(i));
        end
        @(negedge clk);
        {ifa.exp_we, ifb.exp_we, ifc.exp_we} = 3'b000;

        // T1: clean sweep
        sweep_a(1'b0, -1, -1, -1);
        check("t1_pass_err", 32'({ifa.pass, ifa.err_count}), {26'd0, 1'b1, 5'd0});

        // T2: two corrupted entries
        write_a(4'd5, 2'b11);
        write_a(4'd12, 2'b01);
        sweep_a(1'b0, -1, -1, -1);
        check("t2_err_count", 32'(ifa.err_count), 32'd2);
        check("t2_first_err", 32'({ifa.first_err_vld, ifa.first_err_addr}), 32'h15);
        check("t2_pass", 32'(ifa.pass), 32'd0);
`ifdef MFD_CHK_ERRMAP_EN
        check("t2_err_map", 32'(ifa.err_map), 32'h1020);
`endif
        write_a(4'd5, golden(4'd5));
        write_a(4'd12, golden(4'd12));

        // T3: start and table write while busy are both ignored
        sweep_a(1'b0, 10, 12, -1);
        check("t3_pass_err", 32'({ifa.pass, ifa.err_count}), {26'd0, 1'b1, 5'd0});

        // Write on the accepting start edge is used by that sweep
        sweep_a(1'b1, -1, -1, -1);
        check("same_edge_write", 32'({ifa.err_count, ifa.first_err_vld, ifa.first_err_addr}),
              {22'd0, 5'd1, 1'b1, 4'd3});
        write_a(4'd3, golden(4'd3));

        // T4: reset mid-sweep, then a normal sweep
        sweep_a(1'b0, -1, -1, 15);
        sweep_a(1'b0, -1, -1, -1);
        check("t4_pass_after_reset", 32'(ifa.pass), 32'd1);

        // T5 (SETTLE=3) and T6 (ERR_W=3) run side by side
        @(negedge clk);
        ifb.start = 1'b1;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
        cb  = 0;
        cc  = 0;
        cyc = 0;
        while ((cb == 0 || cc == 0) && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ifb.done && cb == 0) cb = cyc;
            if (ifc.done && cc == 0) cc = cyc;
        end
        check("t5_done_cycle", cb, 64);
        check("t5_err_count", 32'(ifb.err_count), 32'd16);
        check("t5_first_err", 32'({ifb.first_err_vld, ifb.first_err_addr, ifb.pass}), {27'd0, 1'b1, 4'd0, 1'b0});
        check("t6_done_cycle", cc, 32);
        check("t6_err_sat", 32'(ifc.err_count), 32'd7);
        check("t6_pass", 32'({ifc.done, ifc.pass}), 32'b10);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
